uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame, legal 5..9.
REQ-002 Parameter OVS, default 16: s_tick pulses per bit period, even, legal 8..32.
REQ-003 Parameter SB_TICK, default 16: s_tick pulses in the stop phase (OVS = 1, 1.5*OVS = 1.5, 2*OVS = 2 stop bits).
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN.
REQ-005 clk  in  1  single system clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 rx  in  1  serial line, asynchronous to clk, idle high.
REQ-008 s_tick  in  1  oversample enable, one-clk pulse, OVS pulses per bit.
REQ-009 rx_done_tick  out  1  one-clk pulse, frame complete.
REQ-010 dout  out  DBIT  last received word, LSB = first data bit.
REQ-011 frame_err  out  1  stop bit sampled low in last frame.
REQ-012 parity_err  out  1  parity mismatch in last frame; constant 0 without UART_RX_PARITY_EN.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; tick counter s (5 bits) and bit counter n advance only on s_tick.
REQ-016 IDLE->START SHALL occur on a falling edge of rx_s (previous rx_s high, current low), clearing s; a line held low SHALL never start a frame.
REQ-017 In START, at s = OVS/2-1 with s_tick: rx_s low -> DATA with s,n cleared; rx_s high -> false start, back to IDLE, no rx_done_tick.
REQ-018 In DATA, at s = OVS-1 with s_tick: rx_s shifts into the MSB of the shift register (LSB-first reception), s cleared; after bit DBIT-1 -> PARITY if UART_RX_PARITY_EN, else STOP; otherwise n increments.
REQ-019 In PARITY, at s = OVS-1 with s_tick: sampled bit XOR data XOR PARITY_ODD nonzero sets a pending parity error; -> STOP, s cleared.
REQ-020 In STOP, at s = OVS-1 with s_tick: rx_s low sets a pending frame error; at s = SB_TICK-1 with s_tick: -> IDLE, rx_done_tick high for that one clk.
REQ-021 dout, frame_err and parity_err SHALL update in the same clk edge that raises rx_done_tick and hold until the next rx_done_tick.
REQ-022 A frame with frame_err SHALL still assert rx_done_tick and present dout.
REQ-023 Without s_tick, the FSM and counters SHALL hold; rx edges during START/DATA/PARITY/STOP other than at sample points are ignored.
REQ-024 Latency: rx_done_tick SHALL rise 1 clk after the s_tick ending the stop phase.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, s = 0, n = 0, shift register = 0, dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0, busy = 0, synchronizer flops = 1.
REQ-026 Reset mid-frame SHALL abort with no rx_done_tick; the next frame needs a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN: defined -> PARITY state and parity_err logic are built; undefined -> PARITY is never entered, DATA goes directly to STOP, parity_err tied 0.

Structure
REQ-028 The FSM state typedef, state encodings and the DBIT/OVS legal limits SHALL live in shared package uart_pkg.
REQ-029 The synchronizer and falling-edge detect SHALL be the sub-module uart_rx_sync (ports clk, reset_n, rx, rx_s, fall).

Verification
REQ-030 DBIT=8, OVS=16, SB_TICK=16, frame 0xA5 with a valid stop bit -> one rx_done_tick, dout=0xA5, frame_err=0.
REQ-031 Low glitch of 4 ticks on idle line -> return to IDLE at tick 7, no rx_done_tick, busy low again.
REQ-032 Frame 0x3C with the stop bit driven low -> rx_done_tick, dout=0x3C, frame_err=1; next good frame 0x01 -> frame_err=0.
REQ-033 UART_RX_PARITY_EN, PARITY_ODD=0, frame 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-034 Line held low 40 bit times after a frame -> exactly one rx_done_tick with frame_err=1 and no retrigger until rx returns high and falls again.
REQ-035 reset_n pulsed low during bit 4 of a frame -> outputs zero immediately, no rx_done_tick; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, counter widths and legal parameter limits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DBIT_MIN = 5;
  localparam int DBIT_MAX = 9;
  localparam int OVS_MIN  = 8;
  localparam int OVS_MAX  = 32;

  // Tick counter s and bit counter n widths.
  localparam int S_W = 5;
  localparam int N_W = 4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus falling-edge detect on the synchronized value.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_s_d;

  // NOTE: the flops reset high (idle line level) so leaving reset on an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with mid-bit sampling, frame error and optional parity check.
// Parity support is built only when the macro UART_RX_PARITY_EN is defined.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam bit CFG_OK = (DBIT >= DBIT_MIN) && (DBIT <= DBIT_MAX) &&
                          (OVS >= OVS_MIN) && (OVS <= OVS_MAX) && (OVS % 2 == 0) &&
                          (SB_TICK >= OVS) && (SB_TICK <= (1 << S_W)) &&
                          ((PARITY_ODD == 0) || (PARITY_ODD == 1));

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("uart_rx_cfg: illegal DBIT/OVS/SB_TICK/PARITY_ODD combination");
    end
  endgenerate

  localparam logic [S_W-1:0] S_MID  = S_W'(OVS / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .fall    (fall)
  );

  state_t          state;
  logic [S_W-1:0]  s;
  logic [N_W-1:0]  n;
  logic [DBIT-1:0] b;
  logic            fe_pend;
  logic            stop_low;

  // Stop bit seen low at its mid-bit sample point; only meaningful in STOP with s_tick.
  assign stop_low = (s == S_BIT) && !rx_s;

`ifdef UART_RX_PARITY_EN
  logic pe_pend;
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // NOTE: all FSM state and registered outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      fe_pend      <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_pend      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            s     <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state   <= DATA;
                s       <= '0;
                n       <= '0;
                fe_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
                pe_pend <= 1'b0;
`endif
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) state <= AFTER_DATA;
              else             n     <= n + 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              pe_pend <= rx_s ^ (^b) ^ (PARITY_ODD != 0);
              state   <= STOP;
              s       <= '0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (s_tick) begin
            // With one stop bit the sample point and the end of the stop phase coincide.
            if (s == S_STOP) begin
              state        <= IDLE;
              busy         <= 1'b0;
              rx_done_tick <= 1'b1;
              dout         <= b;
              frame_err    <= fe_pend | stop_low;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= pe_pend;
`endif
            end else begin
              s <= s + 1'b1;
              if (stop_low) fe_pend <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
